// File: rtl/reg_file_sweep.sv
// reg_file_sweep: parametrised register file with a sequenced clear sweep.
//
// Holds DEPTH = 2**AW registers of DW bits. Two combinational operand read
// ports, plus fixed taps on the accumulator (ACC_IDX) and status (STAT_IDX)
// registers. A flag-update port loads the status register with a
// zero-extended flag value. Asserting start launches a sweep that zeroes
// one entry per cycle for DEPTH cycles. During the sweep, writes and flag
// updates are rejected and reported on wr_drop.
//
// Ports:
//   clk            clock, all state updates on posedge
//   rst_n          asynchronous active-low reset
//   start          request (or restart) a clear sweep
//   wr_en          write enable
//   wr_addr        write address
//   dat_in         write data
//   flag_en        load flag_in into the status register
//   flag_in        flag value, zero-extended into status bits [FW-1:0]
//   rd_addr_a      read address, port A
//   rd_addr_b      read address, port B
//   dat_a_out      port A read data
//   dat_b_out      port B read data
//   dat_acc_out    contents of the accumulator register
//   dat_status_out contents of the status register
//   busy           clear sweep in progress
//   wr_drop        write or flag update rejected this cycle

module reg_file_sweep #(
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 4,
    parameter int unsigned ACC_IDX  = 0,
    parameter int unsigned STAT_IDX = 3,
    parameter int unsigned FW       = 1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] dat_in,
    input  logic          flag_en,
    input  logic [FW-1:0] flag_in,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [DW-1:0] dat_a_out,
    output logic [DW-1:0] dat_b_out,
    output logic [DW-1:0] dat_acc_out,
    output logic [DW-1:0] dat_status_out,
    output logic          busy,
    output logic          wr_drop
);

    localparam int unsigned DEPTH = 2 ** AW;

    localparam logic [AW-1:0] AccAddr  = AW'(ACC_IDX);
    localparam logic [AW-1:0] StatAddr = AW'(STAT_IDX);
    localparam logic [AW-1:0] LastCnt  = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    state_e        state_q, state_d;
    // AW bits suffice: the counter wraps to 0 by explicit compare against
    // LastCnt, so it can never index outside the array.
    logic [AW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] core_q [DEPTH];

    logic          wr_acc;
    logic          flag_acc;
    logic [DW-1:0] flag_ext;

    // ------------------------------------------------------------------
    // Write / flag acceptance
    // ------------------------------------------------------------------
    assign busy     = (state_q == StClear);
    assign wr_drop  = busy & (wr_en | flag_en);
    assign wr_acc   = ~busy & wr_en;
    // An explicit write to the status register takes priority over a flag load.
    assign flag_acc = ~busy & flag_en & ~(wr_en && (wr_addr == StatAddr));
    assign flag_ext = DW'(flag_in);

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                if (start) begin
                    // Restart: sweep begins again from entry 0.
                    cnt_d = '0;
                end else if (cnt_q == LastCnt) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_q <= '{default: '0};
        end else if (busy) begin
            core_q[cnt_q] <= '0;
        end else begin
            if (wr_acc) begin
                core_q[wr_addr] <= dat_in;
            end
            if (flag_acc) begin
                core_q[StatAddr] <= flag_ext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read paths. Forwarding only applies to accepted writes, so it is
    // implicitly off during a sweep.
    // ------------------------------------------------------------------
    always_comb begin
        dat_a_out = core_q[rd_addr_a];
        if (BYPASS && wr_acc && (rd_addr_a == wr_addr)) begin
            dat_a_out = dat_in;
        end
    end

    always_comb begin
        dat_b_out = core_q[rd_addr_b];
        if (BYPASS && wr_acc && (rd_addr_b == wr_addr)) begin
            dat_b_out = dat_in;
        end
    end

    always_comb begin
        dat_acc_out = core_q[AccAddr];
        if (BYPASS && wr_acc && (wr_addr == AccAddr)) begin
            dat_acc_out = dat_in;
        end
    end

    always_comb begin
        dat_status_out = core_q[StatAddr];
        if (BYPASS) begin
            if (wr_acc && (wr_addr == StatAddr)) begin
                dat_status_out = dat_in;
            end else if (flag_acc) begin
                dat_status_out = flag_ext;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sweep.sv
`timescale 1ns/1ps

module tb_reg_file_sweep;

    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] dat_in = '0;
    logic       flag_en = 1'b0;
    logic [0:0] flag_in = '0;
    logic [3:0] rd_addr_a = '0;
    logic [3:0] rd_addr_b = '0;

    logic [7:0] dat_a_out, dat_b_out, dat_acc_out, dat_status_out;
    logic       busy, wr_drop;
    logic [7:0] nb_dat_a_out, nb_dat_b_out, nb_dat_acc_out, nb_dat_status_out;
    logic       nb_busy, nb_wr_drop;

    int checks = 0;
    int errors = 0;

    always #HALF clk = ~clk;

    reg_file_sweep #(
        .DW(8), .AW(4), .ACC_IDX(0), .STAT_IDX(3), .FW(1), .BYPASS(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
        .dat_in(dat_in), .flag_en(flag_en), .flag_in(flag_in),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .dat_a_out(dat_a_out), .dat_b_out(dat_b_out), .dat_acc_out(dat_acc_out),
        .dat_status_out(dat_status_out), .busy(busy), .wr_drop(wr_drop)
    );

    reg_file_sweep #(
        .DW(8), .AW(4), .ACC_IDX(0), .STAT_IDX(3), .FW(1), .BYPASS(1'b0)
    ) dut_nb (
        .clk(clk), .rst_n(rst_n), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
        .dat_in(dat_in), .flag_en(flag_en), .flag_in(flag_in),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .dat_a_out(nb_dat_a_out), .dat_b_out(nb_dat_b_out),
        .dat_acc_out(nb_dat_acc_out), .dat_status_out(nb_dat_status_out),
        .busy(nb_busy), .wr_drop(nb_wr_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load every register with index+1.
    task automatic fill_incr();
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            dat_in  = 8'(i + 1);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (wr_drop !== 1'b0) begin
            errors++; $display("FAIL reset_wr_drop got %b want 0", wr_drop);
        end
        checks++;
        if (dat_acc_out !== 8'h00 || dat_status_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_taps got acc=%h st=%h want 00 00", dat_acc_out, dat_status_out);
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            #1;
            checks++;
            if (dat_a_out !== 8'h00) begin
                errors++; $display("FAIL reset_reg%0d got %h want 00", i, dat_a_out);
            end
        end
    endtask

    task automatic test_write_bypass();
        wr_en = 1'b1; wr_addr = 4'd5; dat_in = 8'hA5;
        rd_addr_a = 4'd5; rd_addr_b = 4'd5;
        #1;
        checks++;
        if (dat_b_out !== 8'hA5) begin
            errors++; $display("FAIL bypass_b got %h want a5", dat_b_out);
        end
        checks++;
        if (nb_dat_b_out !== 8'h00) begin
            errors++; $display("FAIL nobypass_b got %h want 00", nb_dat_b_out);
        end
        tick();
        wr_en = 1'b0;
        #1;
        checks++;
        if (dat_a_out !== 8'hA5 || nb_dat_a_out !== 8'hA5) begin
            errors++;
            $display("FAIL write_readback got %h/%h want a5", dat_a_out, nb_dat_a_out);
        end
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1; wr_addr = 4'd6; dat_in = 8'h12;
        tick();
        wr_addr = 4'd7; dat_in = 8'h34; rd_addr_a = 4'd6; rd_addr_b = 4'd7;
        #1;
        checks++;
        if (dat_a_out !== 8'h12) begin
            errors++; $display("FAIL b2b_prev got %h want 12", dat_a_out);
        end
        checks++;
        if (dat_b_out !== 8'h34 || nb_dat_b_out !== 8'h00) begin
            errors++;
            $display("FAIL b2b_bypass got %h/%h want 34/00", dat_b_out, nb_dat_b_out);
        end
        tick();
        wr_en = 1'b0;
        #1;
        checks++;
        if (nb_dat_b_out !== 8'h34) begin
            errors++; $display("FAIL b2b_commit got %h want 34", nb_dat_b_out);
        end
    endtask

    task automatic test_acc_flag();
        wr_en = 1'b1; wr_addr = 4'd0; dat_in = 8'h3C; flag_en = 1'b1; flag_in = 1'b1;
        #1;
        checks++;
        if (dat_acc_out !== 8'h3C || dat_status_out !== 8'h01) begin
            errors++;
            $display("FAIL acc_flag_bypass got %h/%h want 3c/01", dat_acc_out, dat_status_out);
        end
        checks++;
        if (nb_dat_acc_out !== 8'h00 || nb_dat_status_out !== 8'h00) begin
            errors++;
            $display("FAIL acc_flag_nobypass got %h/%h want 00/00",
                     nb_dat_acc_out, nb_dat_status_out);
        end
        tick();
        wr_en = 1'b0; flag_en = 1'b0;
        #1;
        checks++;
        if (nb_dat_acc_out !== 8'h3C || nb_dat_status_out !== 8'h01) begin
            errors++;
            $display("FAIL acc_flag_commit got %h/%h want 3c/01",
                     nb_dat_acc_out, nb_dat_status_out);
        end
        wr_en = 1'b1; wr_addr = 4'd3; dat_in = 8'hF0; flag_en = 1'b1; flag_in = 1'b0;
        #1;
        checks++;
        if (dat_status_out !== 8'hF0) begin
            errors++; $display("FAIL write_wins_bypass got %h want f0", dat_status_out);
        end
        tick();
        wr_en = 1'b0; flag_en = 1'b0;
        #1;
        checks++;
        if (dat_status_out !== 8'hF0 || nb_dat_status_out !== 8'hF0) begin
            errors++;
            $display("FAIL write_wins got %h/%h want f0", dat_status_out, nb_dat_status_out);
        end
    endtask

    task automatic test_sweep();
        int n;
        fill_incr();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            if (n == 3) begin
                wr_en = 1'b1; wr_addr = 4'd15; dat_in = 8'h77; rd_addr_b = 4'd15;
                #1;
                checks++;
                if (wr_drop !== 1'b1) begin
                    errors++; $display("FAIL sweep_wr_drop got %b want 1", wr_drop);
                end
                checks++;
                if (dat_b_out !== 8'h10) begin
                    errors++; $display("FAIL sweep_no_bypass got %h want 10", dat_b_out);
                end
            end
            if (n == 4) begin
                #1;
                checks++;
                if (wr_drop !== 1'b0) begin
                    errors++; $display("FAIL sweep_idle_drop got %b want 0", wr_drop);
                end
            end
            if (n == 5) begin
                flag_en = 1'b1; flag_in = 1'b1;
                #1;
                checks++;
                if (wr_drop !== 1'b1) begin
                    errors++; $display("FAIL sweep_flag_drop got %b want 1", wr_drop);
                end
            end
            if (n == 8) begin
                for (int i = 0; i < 16; i++) begin
                    logic [7:0] exp;
                    exp = (i < 8) ? 8'h00 : 8'(i + 1);
                    rd_addr_a = 4'(i);
                    #1;
                    checks++;
                    if (dat_a_out !== exp) begin
                        errors++;
                        $display("FAIL mid_sweep_reg%0d got %h want %h", i, dat_a_out, exp);
                    end
                end
            end
            n++;
            tick();
            wr_en = 1'b0; flag_en = 1'b0;
        end
        checks++;
        if (n != 16) begin
            errors++; $display("FAIL sweep_len got %0d want 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            #1;
            checks++;
            if (dat_a_out !== 8'h00) begin
                errors++; $display("FAIL post_sweep_reg%0d got %h want 00", i, dat_a_out);
            end
        end
    endtask

    task automatic test_restart();
        int n;
        fill_incr();
        // Write and flag update in the start cycle are still accepted.
        start = 1'b1; wr_en = 1'b1; wr_addr = 4'd9; dat_in = 8'h99;
        flag_en = 1'b1; flag_in = 1'b1;
        #1;
        checks++;
        if (wr_drop !== 1'b0) begin
            errors++; $display("FAIL start_cycle_drop got %b want 0", wr_drop);
        end
        tick();
        start = 1'b0; wr_en = 1'b0; flag_en = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            if (n == 0) begin
                rd_addr_a = 4'd9;
                #1;
                checks++;
                if (dat_a_out !== 8'h99 || dat_status_out !== 8'h01) begin
                    errors++;
                    $display("FAIL start_cycle_accept got %h/%h want 99/01",
                             dat_a_out, dat_status_out);
                end
            end
            if (n == 3) start = 1'b1;
            if (n == 10) begin
                rd_addr_a = 4'd5; rd_addr_b = 4'd6;
                #1;
                checks++;
                if (dat_a_out !== 8'h00 || dat_b_out !== 8'h07) begin
                    errors++;
                    $display("FAIL restart_mid got %h/%h want 00/07", dat_a_out, dat_b_out);
                end
            end
            n++;
            tick();
            start = 1'b0;
        end
        checks++;
        if (n != 20) begin
            errors++; $display("FAIL restart_len got %0d want 20", n);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            #1;
            checks++;
            if (dat_a_out !== 8'h00) begin
                errors++; $display("FAIL post_restart_reg%0d got %h want 00", i, dat_a_out);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        fill_incr();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 6) begin
            n++;
            tick();
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL pre_reset_busy got %b want 1", busy);
        end
        rd_addr_a = 4'd12; rd_addr_b = 4'd15;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL async_reset_busy got %b want 0", busy);
        end
        checks++;
        if (dat_a_out !== 8'h00 || dat_b_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_regs got %h/%h want 00/00", dat_a_out, dat_b_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL no_resume got %b want 0", busy);
        end
        wr_en = 1'b1; wr_addr = 4'd2; dat_in = 8'h11;
        tick();
        wr_en = 1'b0; rd_addr_a = 4'd2;
        #1;
        checks++;
        if (dat_a_out !== 8'h11) begin
            errors++; $display("FAIL post_reset_write got %h want 11", dat_a_out);
        end
    endtask

    initial begin
        #(2 * HALF * 5000);
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_bypass();
        test_back_to_back();
        test_acc_flag();
        test_sweep();
        test_restart();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
